// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the memory-port arbiter and its fetch buffer:
//   - arb_state_e   : arbiter FSM states (IDLE / FETCH / DATA)
//   - DEF_ADDR_W    : default address width
//   - DEF_DATA_W    : default data width
//   - DEF_NOP_INSTR : instruction fed to IF/ID when no fetch is valid (addi x0,x0,0)
package pipe_ctrl_pkg;

  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_fetch_hold_buf.sv
// fetch_hold_buf
// One-entry holding register for a fetched instruction. It keeps the
// instruction until the pipeline accepts it, so stalls do not force a refetch.
// Only built when FETCH_HOLD_BUF_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din and mark the entry full
//   consume    : the pipeline took the entry; mark it empty
//   din        : instruction coming back from memory
//   valid      : entry is full
//   dout       : held instruction
`ifdef FETCH_HOLD_BUF_EN
module fetch_hold_buf
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              consume,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  // A load only happens while the entry is empty, so it cannot collide with
  // a consume; load still wins to keep the priority explicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// load/store (MEM). Data accesses win because they belong to the older
// instruction. Also produces the pipeline freeze / PC-write / bubble controls,
// merging in the load-use stall from the hazard detector.
//
// Configuration macro:
//   FETCH_HOLD_BUF_EN defined   : a fetched instruction is held in a 1-entry
//                                 buffer until pc_write accepts it.
//   FETCH_HOLD_BUF_EN undefined : a fetched instruction is valid for exactly one
//                                 cycle; if not accepted the same PC is refetched.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req, if_addr            : fetch request and PC
//   if_instr, if_valid         : instruction for IF/ID (NOP_INSTR when not valid)
//   d_req, d_we, d_be, d_addr,
//   d_wdata                    : MEM-stage access request
//   d_rdata, d_done            : load data and one-cycle completion pulse
//   mem_en, mem_we, mem_be,
//   mem_addr, mem_wdata        : registered memory request
//   mem_rdata, mem_ready       : memory response
//   hz_stall                   : load-use stall from hazard detector
//   pc_write, ifid_write       : PC and IF/ID register enables
//   idex_bubble                : zero ID/EX control bits
//   pipe_hold                  : freeze EX/MEM and MEM/WB
module mem_port_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_instr,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                hz_stall,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                idex_bubble,
  output logic                pipe_hold
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              issue_d;
  logic              issue_f;
  logic              go_idle;
  logic              fetch_done;
  logic              data_done;
  logic              d_served;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_instr;
  logic              buf_empty;

  assign fetch_done = (state == FETCH) && mem_ready;
  assign data_done  = (state == DATA)  && mem_ready;

  // While an instruction is being presented no new fetch may be issued: in
  // the cycle it is accepted the PC has not advanced yet, so issuing then
  // would latch the stale PC.
  assign buf_empty = !buf_valid;

  assign if_valid    = buf_valid;
  assign if_instr    = buf_valid ? buf_instr : NOP_INSTR;
  assign pipe_hold   = d_req && !d_done;
  assign pc_write    = if_valid && !pipe_hold && !hz_stall;
  assign ifid_write  = pc_write;
  assign idex_bubble = hz_stall && !pipe_hold;

`ifdef FETCH_HOLD_BUF_EN
  fetch_hold_buf #(
    .DATA_W (DATA_W)
  ) u_fetch_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (fetch_done),
    .consume (pc_write),
    .din     (mem_rdata),
    .valid   (buf_valid),
    .dout    (buf_instr)
  );
`else
  // Without the buffer a fetched instruction lives for one cycle only; if the
  // pipeline does not take it, the arbiter simply fetches the same PC again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_instr <= '0;
    end else begin
      buf_valid <= fetch_done;
      if (fetch_done) begin
        buf_instr <= mem_rdata;
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and issue decisions. An access in flight is never aborted; a
  // new decision is only made in IDLE or in the cycle mem_ready completes it.
  always_comb begin
    state_nxt = state;
    issue_d   = 1'b0;
    issue_f   = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !d_served) begin
          state_nxt = DATA;
          issue_d   = 1'b1;
        end else if (if_req && buf_empty) begin
          state_nxt = FETCH;
          issue_f   = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          if (d_req && !d_served) begin
            state_nxt = DATA;
            issue_d   = 1'b1;
          end else if (if_req && pc_write) begin
            state_nxt = FETCH;
            issue_f   = 1'b1;
          end else begin
            state_nxt = IDLE;
            go_idle   = 1'b1;
          end
        end
      end
      DATA: begin
        if (mem_ready) begin
          if (if_req && buf_empty) begin
            state_nxt = FETCH;
            issue_f   = 1'b1;
          end else begin
            state_nxt = IDLE;
            go_idle   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        go_idle   = 1'b1;
      end
    endcase
  end

  // Memory request registers: loaded once at issue and held unchanged until
  // the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue_d) begin
      mem_en    <= 1'b1;
      mem_we    <= d_we;
      mem_be    <= d_be;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (issue_f) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= '1;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
    end else if (go_idle) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
    end
  end

  // Data completion and the served flag. d_served stops the same MEM-stage
  // request from being issued twice while d_req is still high in the
  // d_done cycle; it drops once the pipeline advances or d_req goes away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_done   <= 1'b0;
      d_rdata  <= '0;
      d_served <= 1'b0;
    end else begin
      d_done <= data_done;
      if (data_done) begin
        d_rdata  <= mem_rdata;
        d_served <= 1'b1;
      end else if (!d_req || !pipe_hold) begin
        d_served <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The memory side is driven by hand
// (mem_ready / mem_rdata per cycle). Inputs change 1 time unit after the
// rising edge, outputs are sampled 2 units later. Expectations depend on
// FETCH_HOLD_BUF_EN where the buffer changes behaviour.
module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_HOLD_BUF_EN
  localparam logic BUF_ON = 1'b1;
`else
  localparam logic BUF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        hz_stall;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        pipe_hold;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .hz_stall    (hz_stall),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .pipe_hold   (pipe_hold)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_be      = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    hz_stall  = 1'b0;

    // Reset state
    #3;
    check_output("rst_mem_en",   mem_en,    0);
    check_output("rst_mem_we",   mem_we,    0);
    check_output("rst_mem_be",   mem_be,    0);
    check_output("rst_mem_addr", mem_addr,  0);
    check_output("rst_d_done",   d_done,    0);
    check_output("rst_d_rdata",  d_rdata,   0);
    check_output("rst_if_valid", if_valid,  0);
    check_output("rst_if_instr", if_instr,  NOP);
    check_output("rst_pc_write", pc_write,  0);
    apply_stimulus();
    rst_n = 1'b1;

    // Fetch only, zero-wait memory
    apply_stimulus();
    if_req = 1'b1; if_addr = 32'h0;
    #2; check_output("t1_c0_mem_en", mem_en, 0);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    #2;
    check_output("t1_c1_mem_en",   mem_en,   1);
    check_output("t1_c1_mem_addr", mem_addr, 32'h0);
    check_output("t1_c1_mem_we",   mem_we,   0);
    check_output("t1_c1_if_valid", if_valid, 0);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0; if_req = 1'b0;
    #2;
    check_output("t1_c2_if_valid",   if_valid,   1);
    check_output("t1_c2_if_instr",   if_instr,   32'h0050_0093);
    check_output("t1_c2_pc_write",   pc_write,   1);
    check_output("t1_c2_ifid_write", ifid_write, 1);
    check_output("t1_c2_mem_en",     mem_en,     0);
    apply_stimulus();
    #2;
    check_output("t1_c3_if_valid", if_valid, 0);
    check_output("t1_c3_if_instr", if_instr, NOP);

    // Load with a fetch also pending: data goes first, then the fetch
    apply_stimulus();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h4;
    #2;
    check_output("t2_c0_pipe_hold", pipe_hold, 1);
    check_output("t2_c0_mem_en",    mem_en,    0);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #2;
    check_output("t2_c1_mem_en",    mem_en,    1);
    check_output("t2_c1_mem_addr",  mem_addr,  32'h100);
    check_output("t2_c1_mem_we",    mem_we,    0);
    check_output("t2_c1_pipe_hold", pipe_hold, 1);
    check_output("t2_c1_d_done",    d_done,    0);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check_output("t2_c2_d_done",    d_done,    1);
    check_output("t2_c2_d_rdata",   d_rdata,   32'hCAFE_F00D);
    check_output("t2_c2_pipe_hold", pipe_hold, 0);
    check_output("t2_c2_mem_en",    mem_en,    1);
    check_output("t2_c2_mem_addr",  mem_addr,  32'h4);
    apply_stimulus();
    d_req = 1'b0;
    #2;
    check_output("t2_c3_d_done",   d_done,   0);
    check_output("t2_c3_mem_addr", mem_addr, 32'h4);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h00A0_0113; if_req = 1'b0;
    #2;
    check_output("t2_c4_mem_addr", mem_addr, 32'h4);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check_output("t2_c5_if_valid", if_valid, 1);
    check_output("t2_c5_if_instr", if_instr, 32'h00A0_0113);
    check_output("t2_c5_pc_write", pc_write, 1);
    check_output("t2_c5_mem_en",   mem_en,   0);
    apply_stimulus();
    #2;
    check_output("t2_c6_if_valid", if_valid, 0);

    // Store with mem_ready delayed three cycles
    apply_stimulus();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #2;
    check_output("t3_c0_mem_en", mem_en, 0);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus();
      mem_ready = (i == 4);
      #2;
      check_output("t3_hold_mem_en",    mem_en,    1);
      check_output("t3_hold_mem_we",    mem_we,    1);
      check_output("t3_hold_mem_be",    mem_be,    4'b0011);
      check_output("t3_hold_mem_addr",  mem_addr,  32'h200);
      check_output("t3_hold_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_output("t3_hold_d_done",    d_done,    0);
    end
    apply_stimulus();
    mem_ready = 1'b0;
    #2;
    check_output("t3_c5_d_done",    d_done,    1);
    check_output("t3_c5_pipe_hold", pipe_hold, 0);
    check_output("t3_c5_mem_en",    mem_en,    0);
    check_output("t3_c5_mem_we",    mem_we,    0);
    apply_stimulus();
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_wdata = '0;
    #2;
    check_output("t3_c6_d_done", d_done, 0);
    check_output("t3_c6_mem_en", mem_en, 0);

    // Load-use stall while an instruction is presented
    apply_stimulus();
    if_req = 1'b1; if_addr = 32'h8;
    #2;
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h0020_8033;
    #2;
    check_output("t4_c1_mem_addr", mem_addr, 32'h8);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0; hz_stall = 1'b1;
    #2;
    check_output("t4_c2_if_valid",    if_valid,    1);
    check_output("t4_c2_if_instr",    if_instr,    32'h0020_8033);
    check_output("t4_c2_idex_bubble", idex_bubble, 1);
    check_output("t4_c2_pc_write",    pc_write,    0);
    check_output("t4_c2_ifid_write",  ifid_write,  0);
`ifdef FETCH_HOLD_BUF_EN
    apply_stimulus();
    hz_stall = 1'b0; if_req = 1'b0;
    #2;
    check_output("t4_c3_if_valid",    if_valid,    1);
    check_output("t4_c3_if_instr",    if_instr,    32'h0020_8033);
    check_output("t4_c3_pc_write",    pc_write,    1);
    check_output("t4_c3_idex_bubble", idex_bubble, 0);
    apply_stimulus();
    #2;
    check_output("t4_c4_if_valid", if_valid, 0);
`else
    apply_stimulus();
    hz_stall = 1'b0;
    #2;
    check_output("t4_c3_if_valid", if_valid, 0);
    check_output("t4_c3_if_instr", if_instr, NOP);
    check_output("t4_c3_pc_write", pc_write, 0);
    check_output("t4_c3_mem_en",   mem_en,   0);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h0020_8033; if_req = 1'b0;
    #2;
    check_output("t4_refetch_mem_en",   mem_en,   1);
    check_output("t4_refetch_mem_addr", mem_addr, 32'h8);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check_output("t4_refetch_if_valid", if_valid, 1);
    check_output("t4_refetch_pc_write", pc_write, 1);
    apply_stimulus();
    #2;
    check_output("t4_refetch_done", if_valid, 0);
`endif

    // Stall under freeze gets no bubble; then reset mid-access
    apply_stimulus();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; hz_stall = 1'b1;
    #2;
    check_output("t5_c0_pipe_hold",   pipe_hold,   1);
    check_output("t5_c0_idex_bubble", idex_bubble, 0);
    apply_stimulus();
    hz_stall = 1'b0;
    #2;
    check_output("t5_c1_mem_en",   mem_en,   1);
    check_output("t5_c1_mem_addr", mem_addr, 32'h300);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("t5_async_mem_en",   mem_en,   0);
    check_output("t5_async_mem_addr", mem_addr, 0);
    check_output("t5_async_d_done",   d_done,   0);
    apply_stimulus();
    rst_n = 1'b1; d_req = 1'b0; d_be = '0; d_addr = '0;
    #2;
    check_output("t5_rel_mem_en", mem_en, 0);
    check_output("t5_rel_d_done", d_done, 0);
    apply_stimulus();
    #2;
    check_output("t5_rel2_d_done", d_done, 0);
    check_output("t5_rel2_mem_en", mem_en, 0);

    // d_req rises while a fetch is in flight: the fetch finishes first
    apply_stimulus();
    if_req = 1'b1; if_addr = 32'hC;
    #2;
    apply_stimulus();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    #2;
    check_output("t6_c1_mem_en",    mem_en,    1);
    check_output("t6_c1_mem_addr",  mem_addr,  32'hC);
    check_output("t6_c1_pipe_hold", pipe_hold, 1);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0517;
    #2;
    check_output("t6_c2_mem_addr", mem_addr, 32'hC);
    check_output("t6_c2_mem_we",   mem_we,   0);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0; if_req = 1'b0;
    #2;
    check_output("t6_c3_mem_en",   mem_en,   1);
    check_output("t6_c3_mem_addr", mem_addr, 32'h400);
    check_output("t6_c3_if_valid", if_valid, 1);
    check_output("t6_c3_if_instr", if_instr, 32'h0000_0517);
    check_output("t6_c3_pc_write", pc_write, 0);
    apply_stimulus();
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
    #2;
    check_output("t6_c4_mem_addr", mem_addr, 32'h400);
    check_output("t6_c4_if_valid", if_valid, BUF_ON);
    apply_stimulus();
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check_output("t6_c5_d_done",    d_done,    1);
    check_output("t6_c5_d_rdata",   d_rdata,   32'h1122_3344);
    check_output("t6_c5_pipe_hold", pipe_hold, 0);
    check_output("t6_c5_mem_en",    mem_en,    0);
    check_output("t6_c5_pc_write",  pc_write,  BUF_ON);
    apply_stimulus();
    d_req = 1'b0; d_be = '0;
    #2;
    check_output("t6_c6_d_done",   d_done,   0);
    check_output("t6_c6_if_valid", if_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
